// File: rtl/axi_read_arbiter_pkg.sv
// Shared AXI read-arbiter types and fixed AR attribute encodings.
package axi_pkg;

    localparam logic [2:0] AXI_SIZE_8B       = 3'h3;
    localparam logic [1:0] AXI_BURST_WRAP    = 2'h2;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'h6;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'h0;
    localparam logic       AXI_LOCK_NORMAL   = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } arb_port_t;

    function automatic arb_port_t other_port(input arb_port_t p);
        return (p == PORT_IF) ? PORT_MEM : PORT_IF;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_pick2.sv
// Two-way winner select. ARB_ROUND_ROBIN_EN: ties go to the port that did not win last;
// otherwise ties go to MEM (port 1).
module arb_pick2
    import axi_pkg::*;
(
    input  logic [1:0] req_valid_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  arb_port_t  last_grant_i,
`endif
    output logic       grant_valid_o,
    output arb_port_t  winner_o
);

    // Winner decode; a lone requester always wins regardless of mode
    always_comb begin
        grant_valid_o = |req_valid_i;
        winner_o      = PORT_IF;
        case (req_valid_i)
            2'b01:   winner_o = PORT_IF;
            2'b10:   winner_o = PORT_MEM;
`ifdef ARB_ROUND_ROBIN_EN
            2'b11:   winner_o = other_port(last_grant_i);
`else
            2'b11:   winner_o = PORT_MEM;
`endif
            default: winner_o = PORT_IF;
        endcase
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read channel between instruction fetch (port 0) and data load (port 1),
// one burst outstanding. Define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_last,
    output logic                    rsp_err,
    output logic                    len_err,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    arb_state_t              state_q;
    arb_port_t               owner_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic [1:0]              req_ready_q;
    logic                    len_err_q;
    logic                    len_err_d;
    logic [7:0]              beat_cnt_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [ID_WIDTH-1:0]     arid_q;
    logic                    pick_valid_s;
    arb_port_t               pick_port_s;
    logic                    beat_fire_s;
`ifdef ARB_ROUND_ROBIN_EN
    arb_port_t               last_grant_q;
`endif

    arb_pick2 u_pick (
        .req_valid_i   (req_valid),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant_i  (last_grant_q),
`endif
        .grant_valid_o (pick_valid_s),
        .winner_o      (pick_port_s)
    );

    assign beat_fire_s = (state_q == ARB_DATA) && m_axi_rvalid;

    // Length/ID checking: a wrong rid, an early rlast, or a beat past the last index without rlast
    always_comb begin
        len_err_d = len_err_q;
        if (beat_fire_s) begin
            if (m_axi_rid != arid_q) begin
                len_err_d = 1'b1;
            end else if (m_axi_rlast) begin
                len_err_d = len_err_q | (beat_cnt_q != LAST_BEAT);
            end else begin
                len_err_d = len_err_q | (beat_cnt_q >= LAST_BEAT);
            end
        end else begin
            len_err_d = len_err_q;
        end
    end

    // Arbitration FSM with registered AR/R handshake and grant outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= PORT_IF;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            req_ready_q  <= 2'b00;
            len_err_q    <= 1'b0;
            beat_cnt_q   <= 8'd0;
            araddr_q     <= {ADDR_WIDTH{1'b0}};
            arid_q       <= {ID_WIDTH{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= PORT_MEM;
`endif
        end else begin
            req_ready_q <= 2'b00;
            len_err_q   <= len_err_d;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid_s) begin
                        owner_q   <= pick_port_s;
                        araddr_q  <= (pick_port_s == PORT_MEM) ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                                               : req_addr[ADDR_WIDTH-1:0];
                        arid_q    <= {{(ID_WIDTH-1){1'b0}}, pick_port_s};
                        arvalid_q <= 1'b1;
                        req_ready_q <= (pick_port_s == PORT_MEM) ? 2'b10 : 2'b01;
                        state_q   <= ARB_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= pick_port_s;
`endif
                    end
                end
                ARB_ADDR: begin
                    if (arvalid_q && m_axi_arready) begin
                        arvalid_q  <= 1'b0;
                        rready_q   <= 1'b1;
                        beat_cnt_q <= 8'd0;
                        state_q    <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (m_axi_rvalid) begin
                        // Saturate so an overlong burst cannot wrap back to a "good" count
                        if (beat_cnt_q != 8'hFF) begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                        if (m_axi_rlast) begin
                            rready_q <= 1'b0;
                            state_q  <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= ARB_IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Response routing: only the burst owner sees beats, and only while in DATA
    always_comb begin
        rsp_valid = 2'b00;
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;
        if (state_q == ARB_DATA) begin
            if (owner_q == PORT_MEM) begin
                rsp_valid = {m_axi_rvalid, 1'b0};
            end else begin
                rsp_valid = {1'b0, m_axi_rvalid};
            end
            rsp_last = m_axi_rlast;
            rsp_err  = (m_axi_rresp != 2'b00);
        end else begin
            rsp_valid = 2'b00;
            rsp_last  = 1'b0;
            rsp_err   = 1'b0;
        end
    end

    assign rsp_data      = m_axi_rdata;
    assign req_ready     = req_ready_q;
    assign len_err       = len_err_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = AXI_SIZE_8B;
    assign m_axi_arburst = AXI_BURST_WRAP;
    assign m_axi_arlock  = AXI_LOCK_NORMAL;
    assign m_axi_arcache = AXI_CACHE_DEFAULT;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter; expected ids follow ARB_ROUND_ROBIN_EN.
module tb_axi_read_arbiter;

    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;

    logic           clk;
    logic           reset;
    logic [1:0]     req_valid;
    logic [2*AW-1:0] req_addr;
    logic [1:0]     req_ready;
    logic [1:0]     rsp_valid;
    logic [DW-1:0]  rsp_data;
    logic           rsp_last;
    logic           rsp_err;
    logic           len_err;
    logic [IDW-1:0] m_axi_arid;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic [2:0]     m_axi_arsize;
    logic [1:0]     m_axi_arburst;
    logic           m_axi_arlock;
    logic [3:0]     m_axi_arcache;
    logic [2:0]     m_axi_arprot;
    logic           m_axi_arvalid;
    logic           m_axi_arready;
    logic [IDW-1:0] m_axi_rid;
    logic [DW-1:0]  m_axi_rdata;
    logic [1:0]     m_axi_rresp;
    logic           m_axi_rlast;
    logic           m_axi_rvalid;
    logic           m_axi_rready;

    axi_read_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_err(rsp_err), .len_err(len_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] dbase = 64'hCAFE_0000_0000_0000;
    logic [1:0]  keep_mask = 2'b00;

    int          g_wait, g_hold_bad, g_cnt0, g_cnt1, g_last_idx, g_data_bad, g_rr_bad;
    logic [63:0] g_addr;
    logic [IDW-1:0] g_id;
    logic [7:0]  g_len;
    logic [1:0]  g_grant, g_ab_rsv;
    logic [31:0] g_err_mask, g_lerr_mask;
    logic        g_ar_after, g_rr_on, g_pre_rsv, g_rr_end, g_len_err, g_timeout;
    logic        g_ab_arv, g_ab_rr;

    // Bus model for one burst: records observations; abort_at >= 0 asserts reset before that beat completes
    task automatic run_burst(input int ar_delay, input int nbeats, input int err_beat,
                             input bit bad_rid, input int abort_at);
        g_wait = 0; g_hold_bad = 0; g_cnt0 = 0; g_cnt1 = 0; g_last_idx = -1;
        g_data_bad = 0; g_rr_bad = 0; g_err_mask = '0; g_lerr_mask = '0;
        g_pre_rsv = 1'b0; g_timeout = 1'b0; g_grant = 2'b00;
        for (int i = 1; i <= 20 && g_wait == 0; i++) begin
            @(negedge clk); #1;
            if (m_axi_arvalid === 1'b1) begin
                g_wait = i; g_addr = m_axi_araddr; g_id = m_axi_arid;
                g_len = m_axi_arlen; g_grant = req_ready;
                m_axi_rvalid = 1'b1;
            end
            req_valid = req_valid & ~(req_ready & ~keep_mask);
        end
        if (g_wait == 0) begin
            g_timeout = 1'b1;
            return;
        end
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk); #1;
            if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== g_addr) g_hold_bad++;
            if (rsp_valid !== 2'b00 || m_axi_rready !== 1'b0) g_pre_rsv = 1'b1;
        end
        m_axi_rvalid  = 1'b0;
        m_axi_arready = 1'b1;
        @(negedge clk); #1;
        m_axi_arready = 1'b0;
        g_ar_after = m_axi_arvalid;
        g_rr_on    = m_axi_rready;
        for (int b = 0; b < nbeats; b++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = dbase + 64'(b);
            m_axi_rlast  = (b == nbeats - 1);
            m_axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            m_axi_rid    = bad_rid ? (g_id ^ 13'd1) : g_id;
            #1;
            if (b == abort_at) begin
                reset = 1'b1;
                #1;
                g_ab_arv = m_axi_arvalid; g_ab_rr = m_axi_rready; g_ab_rsv = rsp_valid;
                return;
            end
            if (rsp_valid[0] === 1'b1) g_cnt0++;
            if (rsp_valid[1] === 1'b1) g_cnt1++;
            if (rsp_last === 1'b1) g_last_idx = b;
            if (rsp_err === 1'b1) g_err_mask[b] = 1'b1;
            if (rsp_data !== dbase + 64'(b)) g_data_bad++;
            if (m_axi_rready !== 1'b1) g_rr_bad++;
            g_lerr_mask[b] = len_err;
            @(negedge clk); #1;
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        #1;
        g_rr_end  = m_axi_rready;
        g_len_err = len_err;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 2'b00; m_axi_rvalid = 1'b0; m_axi_arready = 1'b0;
        m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        total++; if (m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b want=0", m_axi_arvalid); end
        total++; if (m_axi_rready !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b want=0", m_axi_rready); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b want=00", req_ready); end
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL rst_len_err got=%b want=0", len_err); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid got=%b want=00", rsp_valid); end
        total++; if (m_axi_araddr !== 64'h0) begin bad++; $display("FAIL rst_araddr got=%h want=0", m_axi_araddr); end
        total++; if (m_axi_arid !== 13'h0) begin bad++; $display("FAIL rst_arid got=%h want=0", m_axi_arid); end
        total++; if (m_axi_arlen !== 8'd7) begin bad++; $display("FAIL arlen got=%0d want=7", m_axi_arlen); end
        total++; if (m_axi_arsize !== 3'h3) begin bad++; $display("FAIL arsize got=%h want=3", m_axi_arsize); end
        total++; if (m_axi_arburst !== 2'h2) begin bad++; $display("FAIL arburst got=%h want=2", m_axi_arburst); end
        total++; if (m_axi_arprot !== 3'h6) begin bad++; $display("FAIL arprot got=%h want=6", m_axi_arprot); end
        total++; if ({m_axi_arlock, m_axi_arcache} !== 5'h0) begin bad++; $display("FAIL arlock_cache got=%h want=0", {m_axi_arlock, m_axi_arcache}); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        req_addr[AW-1:0] = 64'h1000; req_valid = 2'b01;
        run_burst(2, 8, -1, 1'b0, -1);
        total++; if (g_timeout !== 1'b0) begin bad++; $display("FAIL single_timeout got=%b want=0", g_timeout); end
        total++; if (g_wait !== 1) begin bad++; $display("FAIL single_latency got=%0d want=1", g_wait); end
        total++; if (g_addr !== 64'h1000) begin bad++; $display("FAIL single_araddr got=%h want=1000", g_addr); end
        total++; if (g_id !== 13'd0) begin bad++; $display("FAIL single_arid got=%0d want=0", g_id); end
        total++; if (g_len !== 8'd7) begin bad++; $display("FAIL single_arlen got=%0d want=7", g_len); end
        total++; if (g_grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", g_grant); end
        total++; if (g_hold_bad !== 0 || g_pre_rsv !== 1'b0) begin bad++; $display("FAIL single_addr_hold got=%0d/%b want=0/0", g_hold_bad, g_pre_rsv); end
        total++; if ({g_ar_after, g_rr_on} !== 2'b01) begin bad++; $display("FAIL single_handshake got=%b want=01", {g_ar_after, g_rr_on}); end
        total++; if (g_cnt0 !== 8 || g_cnt1 !== 0) begin bad++; $display("FAIL single_beats got=%0d/%0d want=8/0", g_cnt0, g_cnt1); end
        total++; if (g_last_idx !== 7) begin bad++; $display("FAIL single_last got=%0d want=7", g_last_idx); end
        total++; if (g_data_bad !== 0 || g_rr_bad !== 0) begin bad++; $display("FAIL single_data got=%0d/%0d want=0/0", g_data_bad, g_rr_bad); end
        total++; if (g_err_mask !== 32'h0) begin bad++; $display("FAIL single_rsp_err got=%h want=0", g_err_mask); end
        total++; if ({g_len_err, g_rr_end} !== 2'b00) begin bad++; $display("FAIL single_end got=%b want=00", {g_len_err, g_rr_end}); end
    endtask

    task automatic test_priority();
        req_addr = {64'h2000, 64'h1000}; req_valid = 2'b11;
        run_burst(0, 8, -1, 1'b0, -1);
        total++; if (g_id !== 13'd1 || g_addr !== 64'h2000) begin bad++; $display("FAIL prio_first got=id%0d/%h want=id1/2000", g_id, g_addr); end
        total++; if (g_grant !== 2'b10) begin bad++; $display("FAIL prio_grant got=%b want=10", g_grant); end
        total++; if (g_cnt1 !== 8 || g_cnt0 !== 0) begin bad++; $display("FAIL prio_route got=%0d/%0d want=8/0", g_cnt1, g_cnt0); end
        run_burst(0, 8, -1, 1'b0, -1);
        total++; if (g_wait !== 1) begin bad++; $display("FAIL prio_b2b_latency got=%0d want=1", g_wait); end
        total++; if (g_id !== 13'd0 || g_addr !== 64'h1000) begin bad++; $display("FAIL prio_second got=id%0d/%h want=id0/1000", g_id, g_addr); end
        total++; if (g_cnt0 !== 8 || g_cnt1 !== 0) begin bad++; $display("FAIL prio_route2 got=%0d/%0d want=8/0", g_cnt0, g_cnt1); end
    endtask

    task automatic test_rresp_err();
        req_addr[2*AW-1:AW] = 64'h3040; req_valid = 2'b10;
        run_burst(1, 8, 3, 1'b0, -1);
        total++; if (g_err_mask !== 32'h8) begin bad++; $display("FAIL rresp_err got=%h want=8", g_err_mask); end
        total++; if (g_last_idx !== 7 || g_cnt1 !== 8) begin bad++; $display("FAIL rresp_complete got=%0d/%0d want=7/8", g_last_idx, g_cnt1); end
        total++; if (g_len_err !== 1'b0) begin bad++; $display("FAIL rresp_len_err got=%b want=0", g_len_err); end
    endtask

    task automatic test_bad_rid();
        req_addr[AW-1:0] = 64'h4000; req_valid = 2'b01;
        run_burst(0, 8, -1, 1'b1, -1);
        total++; if (g_len_err !== 1'b1) begin bad++; $display("FAIL rid_len_err got=%b want=1", g_len_err); end
        total++; if (g_cnt0 !== 8) begin bad++; $display("FAIL rid_route got=%0d want=8", g_cnt0); end
    endtask

    task automatic test_reset_mid();
        req_addr[AW-1:0] = 64'h4800; req_valid = 2'b01;
        run_burst(0, 8, -1, 1'b0, 3);
        total++; if ({g_ab_arv, g_ab_rr} !== 2'b00) begin bad++; $display("FAIL midrst_bus got=%b want=00", {g_ab_arv, g_ab_rr}); end
        total++; if (g_ab_rsv !== 2'b00) begin bad++; $display("FAIL midrst_rsp_valid got=%b want=00", g_ab_rsv); end
        do_reset();
        #1;
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL midrst_len_err got=%b want=0", len_err); end
        req_addr[AW-1:0] = 64'h5000; req_valid = 2'b01;
        run_burst(0, 8, -1, 1'b0, -1);
        total++; if (g_wait !== 1 || g_addr !== 64'h5000 || g_id !== 13'd0) begin bad++; $display("FAIL midrst_fresh_ar got=%0d/%h/%0d want=1/5000/0", g_wait, g_addr, g_id); end
        total++; if (g_cnt0 !== 8 || g_len_err !== 1'b0) begin bad++; $display("FAIL midrst_burst got=%0d/%b want=8/0", g_cnt0, g_len_err); end
    endtask

    task automatic test_len_short();
        req_addr[AW-1:0] = 64'h6000; req_valid = 2'b01;
        run_burst(0, 6, -1, 1'b0, -1);
        total++; if (g_len_err !== 1'b1) begin bad++; $display("FAIL short_len_err got=%b want=1", g_len_err); end
        total++; if (g_last_idx !== 5 || g_rr_end !== 1'b0) begin bad++; $display("FAIL short_end got=%0d/%b want=5/0", g_last_idx, g_rr_end); end
        req_addr[2*AW-1:AW] = 64'h7000; req_valid = 2'b10;
        run_burst(0, 8, -1, 1'b0, -1);
        total++; if (g_wait !== 1 || g_cnt1 !== 8) begin bad++; $display("FAIL short_next_served got=%0d/%0d want=1/8", g_wait, g_cnt1); end
        total++; if (g_len_err !== 1'b1) begin bad++; $display("FAIL short_sticky got=%b want=1", g_len_err); end
    endtask

    task automatic test_len_long();
        do_reset();
        req_addr[AW-1:0] = 64'h8000; req_valid = 2'b01;
        run_burst(0, 9, -1, 1'b0, -1);
        total++; if (g_lerr_mask[8:7] !== 2'b10) begin bad++; $display("FAIL long_len_err_timing got=%b want=10", g_lerr_mask[8:7]); end
        total++; if (g_last_idx !== 8 || g_cnt0 !== 9) begin bad++; $display("FAIL long_accept got=%0d/%0d want=8/9", g_last_idx, g_cnt0); end
    endtask

    task automatic test_back_to_back();
        logic [IDW-1:0] exp_id [4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_id = '{13'd0, 13'd1, 13'd0, 13'd1};
`else
        exp_id = '{13'd1, 13'd1, 13'd1, 13'd0};
`endif
        req_addr = {64'h200, 64'h100}; req_valid = 2'b11; keep_mask = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) keep_mask = 2'b00;
            run_burst(0, 8, -1, 1'b0, -1);
            total++;
            if (g_wait !== 1 || g_id !== exp_id[k] || g_addr !== ((exp_id[k] == 13'd1) ? 64'h200 : 64'h100)) begin
                bad++;
                $display("FAIL b2b_grant%0d got=%0d/id%0d/%h want=1/id%0d", k, g_wait, g_id, g_addr, exp_id[k]);
            end
        end
        total++; if (req_valid !== 2'b00) begin bad++; $display("FAIL b2b_drained got=%b want=00", req_valid); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; req_addr = '0;
        m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_rresp_err();
        test_bad_rid();
        test_reset_mid();
        test_len_short();
        test_len_long();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
